// File: rtl/idelay_cal_capture_pkg.sv
// -----------------------------------------------------------------------------
// idelay_cal_capture_pkg
// Shared LACCP package for the IDELAYE3 tap-count capture block.
// Holds the capture FSM state type and the default parameter constants used
// by idelay_cal_capture and cal_stable_detect.
// -----------------------------------------------------------------------------
package idelay_cal_capture_pkg;

    localparam int CAL_CNTVALUE_BITS  = 9;
    localparam int CAL_ALIGN_DELAY    = 54;
    localparam int CAL_SETTLE_CYCLES  = 64;
    localparam int CAL_STABLE_COUNT   = 4;
    localparam int CAL_TIMEOUT_CYCLES = 65535;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_RDY,
        ST_SETTLE,
        ST_SAMPLE,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } cal_state_e;

endpackage

// File: rtl/idelay_cal_capture_stable_detect.sv
// -----------------------------------------------------------------------------
// cal_stable_detect
// Qualifies the live master/slave CNTVALUEOUT pair while the capture FSM is
// sampling, and flags (hit_o) the cycle whose pair should be latched.
//
// Default build: counts consecutive identical pairs; hit_o fires on the
// cycle the run length reaches kStableCount, and master_o/slave_o carry the
// current (stable) pair.
// With `CAL_AVERAGE_EN defined: accumulates 8 consecutive pairs; hit_o fires
// on the 8th and master_o/slave_o carry the half-up rounded mean (sum+4)>>3.
//
// Ports:
//   clk_i      clock (rising edge)
//   rstn_i     synchronous active-low reset
//   sample_i   FSM is in SAMPLE; low clears the run/accumulation
//   master_i   live master tap count
//   slave_i    live slave tap count
//   hit_o      latch request (combinational, valid only while sample_i=1)
//   master_o   master value to latch
//   slave_o    slave value to latch
// -----------------------------------------------------------------------------
module cal_stable_detect
    import idelay_cal_capture_pkg::*;
#(
    parameter int kCNTVALUEbit = CAL_CNTVALUE_BITS,
    parameter int kStableCount = CAL_STABLE_COUNT
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    sample_i,
    input  logic [kCNTVALUEbit-1:0] master_i,
    input  logic [kCNTVALUEbit-1:0] slave_i,
    output logic                    hit_o,
    output logic [kCNTVALUEbit-1:0] master_o,
    output logic [kCNTVALUEbit-1:0] slave_o
);

`ifdef CAL_AVERAGE_EN

    localparam int AW = kCNTVALUEbit + 3;

    logic [AW-1:0] acc_m_q, acc_m_d, acc_s_q, acc_s_d;
    logic [AW-1:0] sum_m, sum_s, rnd_m, rnd_s;
    logic [2:0]    n_q, n_d;

    always_comb begin
        sum_m = acc_m_q + AW'(master_i);
        sum_s = acc_s_q + AW'(slave_i);
        rnd_m = sum_m + AW'(4);
        rnd_s = sum_s + AW'(4);
        hit_o    = sample_i && (n_q == 3'd7);
        master_o = rnd_m[AW-1:3];
        slave_o  = rnd_s[AW-1:3];
        acc_m_d  = '0;
        acc_s_d  = '0;
        n_d      = '0;
        if (sample_i && !hit_o) begin
            acc_m_d = sum_m;
            acc_s_d = sum_s;
            n_d     = n_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            acc_m_q <= '0;
            acc_s_q <= '0;
            n_q     <= '0;
        end else begin
            acc_m_q <= acc_m_d;
            acc_s_q <= acc_s_d;
            n_q     <= n_d;
        end
    end

`else

    localparam int            CW = $clog2(kStableCount + 1);
    localparam logic [CW-1:0] K  = CW'(kStableCount);

    logic [kCNTVALUEbit-1:0] prev_m_q, prev_s_q;
    logic [CW-1:0]           cnt_q, cnt_d;

    // cnt_q == 0 means "no previous pair yet", so the first sample after
    // SAMPLE entry always loads the run length with 1.
    always_comb begin
        cnt_d = '0;
        if (sample_i) begin
            if (cnt_q == '0 || master_i != prev_m_q || slave_i != prev_s_q)
                cnt_d = CW'(1);
            else if (cnt_q != K)
                cnt_d = cnt_q + 1'b1;
            else
                cnt_d = cnt_q;
        end
        hit_o    = sample_i && (cnt_d == K);
        master_o = master_i;
        slave_o  = slave_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            cnt_q    <= '0;
            prev_m_q <= '0;
            prev_s_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (sample_i) begin
                prev_m_q <= master_i;
                prev_s_q <= slave_i;
            end
        end
    end

`endif

endmodule

// File: rtl/idelay_cal_capture.sv
// -----------------------------------------------------------------------------
// idelay_cal_capture
// Captures the initial master/slave IDELAYE3 CNTVALUEOUT tap counts once the
// IDELAYCTRL is ready. EN_VTC is held high except while sampling, the pair is
// latched once it qualifies (see cal_stable_detect), and a range check then
// reports init_valid or cal_error. A start pulse in DONE/ERROR re-captures.
//
// Build option: `CAL_AVERAGE_EN selects 8-sample averaging instead of the
// consecutive-stable-pair rule.
//
// Ports:
//   CLK                    clock (rising edge)
//   RSTN                   synchronous active-low reset
//   start                  capture request pulse (honoured in IDLE/DONE/ERROR)
//   idelayctrl_rdy         IDELAYCTRL RDY, synchronous to CLK
//   cntvalueout_master     live master CNTVALUEOUT
//   cntvalueout_slave      live slave CNTVALUEOUT
//   en_vtc                 EN_VTC to both IDELAYE3s (low in SAMPLE/CHECK)
//   CNTVALUEOUTInit        latched master tap count
//   CNTVALUEOUT_slaveInit  latched slave tap count
//   init_valid             latched values are valid (DONE)
//   cal_error              capture failed (ERROR)
// -----------------------------------------------------------------------------
module idelay_cal_capture
    import idelay_cal_capture_pkg::*;
#(
    parameter int kCNTVALUEbit   = CAL_CNTVALUE_BITS,
    parameter int kAlignDelay    = CAL_ALIGN_DELAY,
    parameter int kSettleCycles  = CAL_SETTLE_CYCLES,
    parameter int kStableCount   = CAL_STABLE_COUNT,
    parameter int kTimeoutCycles = CAL_TIMEOUT_CYCLES
) (
    input  logic                    CLK,
    input  logic                    RSTN,
    input  logic                    start,
    input  logic                    idelayctrl_rdy,
    input  logic [kCNTVALUEbit-1:0] cntvalueout_master,
    input  logic [kCNTVALUEbit-1:0] cntvalueout_slave,
    output logic                    en_vtc,
    output logic [kCNTVALUEbit-1:0] CNTVALUEOUTInit,
    output logic [kCNTVALUEbit-1:0] CNTVALUEOUT_slaveInit,
    output logic                    init_valid,
    output logic                    cal_error
);

    localparam int                      TW          = $clog2(kTimeoutCycles + 1);
    localparam logic [TW-1:0]           TMO_MAX     = TW'(kTimeoutCycles);
    localparam logic [TW-1:0]           SETTLE_LAST = TW'(kSettleCycles - 1);
    localparam logic [kCNTVALUEbit-1:0] ALIGN       = kCNTVALUEbit'(kAlignDelay);

    cal_state_e              state_q, state_d;
    logic [TW-1:0]           tmo_q, tmo_d, tmo_inc;
    logic [kCNTVALUEbit-1:0] master_q, slave_q;
    logic                    en_vtc_q, init_valid_q, cal_error_q;

    logic                    det_hit;
    logic [kCNTVALUEbit-1:0] det_master, det_slave;

    cal_stable_detect #(
        .kCNTVALUEbit (kCNTVALUEbit),
        .kStableCount (kStableCount)
    ) u_detect (
        .clk_i    (CLK),
        .rstn_i   (RSTN),
        .sample_i (state_q == ST_SAMPLE),
        .master_i (cntvalueout_master),
        .slave_i  (cntvalueout_slave),
        .hit_o    (det_hit),
        .master_o (det_master),
        .slave_o  (det_slave)
    );

    // One counter serves both the settle delay and the timeout: both are
    // measured from SETTLE entry, so the settle exit is just an early tap.
    assign tmo_inc = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (start) state_d = ST_WAIT_RDY;
            end
            ST_WAIT_RDY: begin
                tmo_d = '0;
                if (idelayctrl_rdy) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                tmo_d = tmo_inc;
                if (!idelayctrl_rdy)            state_d = ST_ERROR;
                else if (tmo_inc == TMO_MAX)    state_d = ST_ERROR;
                else if (tmo_q == SETTLE_LAST)  state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                tmo_d = tmo_inc;
                // A qualifying pair beats a simultaneous timeout.
                if (!idelayctrl_rdy)            state_d = ST_ERROR;
                else if (det_hit)               state_d = ST_CHECK;
                else if (tmo_inc == TMO_MAX)    state_d = ST_ERROR;
            end
            ST_CHECK: begin
                if (master_q > ALIGN && slave_q != '0) state_d = ST_DONE;
                else                                   state_d = ST_ERROR;
            end
            ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_WAIT_RDY;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            master_q     <= '0;
            slave_q      <= '0;
            en_vtc_q     <= 1'b1;
            init_valid_q <= 1'b0;
            cal_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            en_vtc_q     <= !(state_d == ST_SAMPLE || state_d == ST_CHECK);
            init_valid_q <= (state_d == ST_DONE);
            cal_error_q  <= (state_d == ST_ERROR);
            if (state_q == ST_SAMPLE && state_d == ST_CHECK) begin
                master_q <= det_master;
                slave_q  <= det_slave;
            end
        end
    end

    assign en_vtc                = en_vtc_q;
    assign CNTVALUEOUTInit       = master_q;
    assign CNTVALUEOUT_slaveInit = slave_q;
    assign init_valid            = init_valid_q;
    assign cal_error             = cal_error_q;

endmodule

// File: doc/idelay_cal_capture.md
IDELAY_CAL_CAPTURE -- requirements
Module: idelay_cal_capture

Interface
REQ-001 SHALL have parameter kCNTVALUEbit, default 9: width of IDELAYE3 CNTVALUEOUT.
REQ-002 SHALL have parameter kAlignDelay, default 54: master align-delay taps subtracted downstream; the master capture must exceed it.
REQ-003 SHALL have parameter kSettleCycles, default 64: wait after RDY before sampling.
REQ-004 SHALL have parameter kStableCount, default 4: number of consecutive identical sample pairs required.
REQ-005 SHALL have parameter kTimeoutCycles, default 65535: sampling limit, counted from SETTLE entry.
REQ-006 SHALL have port CLK, input, 1: the single clock; all logic is synchronous to its rising edge.
REQ-007 SHALL have port RSTN, input, 1: synchronous, active-low reset.
REQ-008 SHALL have port start, input, 1: pulse that requests a (re)capture.
REQ-009 SHALL have port idelayctrl_rdy, input, 1: IDELAYCTRL RDY, already synchronous to CLK.
REQ-010 SHALL have port cntvalueout_master, input, kCNTVALUEbit: live master CNTVALUEOUT.
REQ-011 SHALL have port cntvalueout_slave, input, kCNTVALUEbit: live slave CNTVALUEOUT.
REQ-012 SHALL have port en_vtc, output, 1: EN_VTC drive to both IDELAYE3 instances.
REQ-013 SHALL have port CNTVALUEOUTInit, output, kCNTVALUEbit: latched master tap count.
REQ-014 SHALL have port CNTVALUEOUT_slaveInit, output, kCNTVALUEbit: latched slave tap count.
REQ-015 SHALL have port init_valid, output, 1: the latched values are valid.
REQ-016 SHALL have port cal_error, output, 1: the capture failed (timeout or range).

Function
REQ-017 SHALL implement FSM states IDLE, WAIT_RDY, SETTLE, SAMPLE, CHECK, DONE, ERROR.
REQ-018 SHALL move IDLE->WAIT_RDY on start; WAIT_RDY->SETTLE on the first cycle idelayctrl_rdy=1.
REQ-019 SHALL hold en_vtc=1 in IDLE/WAIT_RDY/SETTLE/DONE/ERROR and en_vtc=0 in SAMPLE/CHECK.
REQ-020 SHALL spend exactly kSettleCycles cycles in SETTLE, then enter SAMPLE.
REQ-021 SHALL compare the input pair to the previous pair every SAMPLE cycle; equal increments the stable counter, unequal reloads it to 1.
REQ-022 SHALL latch the pair into CNTVALUEOUTInit/CNTVALUEOUT_slaveInit when the stable counter reaches kStableCount, then enter CHECK.
REQ-023 SHALL, in CHECK (one cycle), go to DONE if master>kAlignDelay and slave!=0, else to ERROR.
REQ-024 SHALL assert init_valid in DONE only; cal_error in ERROR only; both are registered and mutually exclusive.
REQ-025 SHALL enter ERROR when the timeout counter reaches kTimeoutCycles in SETTLE or SAMPLE; CHECK has priority over timeout in the same cycle.
REQ-026 SHALL go to ERROR from SETTLE/SAMPLE if idelayctrl_rdy drops.
REQ-027 SHALL restart from WAIT_RDY on start in DONE or ERROR, clearing init_valid/cal_error the next cycle while latched values hold until a new latch.
REQ-028 SHALL ignore start in WAIT_RDY..CHECK.
REQ-029 SHALL saturate the timeout counter (no wrap-around).

Reset
REQ-030 SHALL apply the following on RSTN=0 at the clock edge: state=IDLE, en_vtc=1, CNTVALUEOUTInit=0, CNTVALUEOUT_slaveInit=0, init_valid=0, cal_error=0, all counters 0; reset mid-capture aborts with no latch.

Configuration
REQ-031 SHALL, when macro CAL_AVERAGE_EN is defined, replace the stability check with an average of 8 consecutive SAMPLE pairs, rounded half-up (sum+4)>>3, with accumulators kCNTVALUEbit+3 wide; without the macro, the stability rule REQ-021/022 applies.

Structure
REQ-032 SHALL declare the state enum and default parameter constants in the shared LACCP package.
REQ-033 SHALL contain one sub-module, cal_stable_detect, holding the compare/stable counter or averager.

Verification
REQ-034 SHALL cover: start, RDY high at cycle 5, inputs constant 200/180 -> en_vtc falls after 64 settle cycles, init_valid=1 with outputs 200/180 after 4 samples+CHECK.
REQ-035 SHALL cover: master toggling 200/201 every cycle -> no latch, cal_error=1 at the timeout count of 65535.
REQ-036 SHALL cover: stable pair 50/180 -> cal_error=1, init_valid=0; stable pair 200/0 -> cal_error=1.
REQ-037 SHALL cover: RDY drops during SAMPLE -> ERROR next cycle, en_vtc=1.
REQ-038 SHALL cover: RSTN=0 during SAMPLE -> all outputs reset values next cycle; then start with 210/190 -> clean capture.
REQ-039 SHALL cover, with CAL_AVERAGE_EN: master samples 200x4, 201x4 -> CNTVALUEOUTInit=201.
